// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its memory, decoder, ALU
// and register file. The sequencer is the master; the datapath side is the slave.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [38:0]       imem_data;
    logic [38:0]       instruction;
    logic              dec_strobe;
    logic              alu_start;
    logic [2:0]        alu_op;
    logic              alu_done;
    logic              wb_en;
    logic [3:0]        wb_addr;

    modport master (
        output imem_addr, imem_rd, instruction, dec_strobe,
               alu_start, alu_op, wb_en, wb_addr,
        input  imem_data, alu_done
    );

    modport slave (
        input  imem_addr, imem_rd, instruction, dec_strobe,
               alu_start, alu_op, wb_en, wb_addr,
        output imem_data, alu_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches 39-bit words, strobes the decoder,
// runs two-operand opcodes through the ALU with a bounded wait, then writes back.
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    instr_sequencer_if.master  seq_bus,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_timeout_err,
    output logic [15:0]        o_retired,
    output logic [ADDR_W-1:0]  o_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [2:0]  OP_HALT     = 3'd0;
    localparam logic [2:0]  OP_LDA      = 3'd1;
    localparam logic [2:0]  OP_LDB      = 3'd2;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_imem_addr;
    logic              r_imem_rd;
    logic [38:0]       r_instruction;
    logic              r_dec_strobe;
    logic              r_alu_start;
    logic [2:0]        r_alu_op;
    logic              r_wb_en;
    logic [3:0]        r_wb_addr;
    logic              r_busy;
    logic              r_halted;
    logic              r_timeout_err;
    logic [15:0]       r_retired;
    logic [15:0]       r_wait_cnt;

    logic [2:0]        w_opcode;
    logic [15:0]       w_wait_next;

    assign w_opcode    = r_instruction[38:36];
    assign w_wait_next = r_wait_cnt + 16'd1;

    // Every output is a register updated on the transition into the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_imem_addr   <= '0;
            r_imem_rd     <= 1'b0;
            r_instruction <= '0;
            r_dec_strobe  <= 1'b0;
            r_alu_start   <= 1'b0;
            r_alu_op      <= '0;
            r_wb_en       <= 1'b0;
            r_wb_addr     <= '0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_retired     <= '0;
            r_wait_cnt    <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are only raised on entry to
            // their owning state, so each one lasts exactly one cycle.
            r_imem_rd    <= 1'b0;
            r_dec_strobe <= 1'b0;
            r_alu_start  <= 1'b0;
            r_wb_en      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_FETCH;
                        r_imem_addr <= r_pc;
                        r_imem_rd   <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                S_FETCH: begin
                    r_state <= S_LATCH;
                end

                S_LATCH: begin
                    r_instruction <= seq_bus.imem_data;
                    r_pc          <= r_pc + ADDR_W'(1);
                    r_dec_strobe  <= 1'b1;
                    r_state       <= S_DECODE;
                end

                S_DECODE: begin
                    if (w_opcode == OP_HALT) begin
                        r_state     <= S_HALT;
                        r_halted    <= 1'b1;
                        r_busy      <= 1'b0;
                        r_imem_addr <= '0;
                    end else if (w_opcode == OP_LDA || w_opcode == OP_LDB) begin
                        r_retired   <= r_retired + 16'd1;
                        r_state     <= S_FETCH;
                        r_imem_addr <= r_pc;
                        r_imem_rd   <= 1'b1;
                    end else begin
                        r_state     <= S_EXEC;
                        r_alu_start <= 1'b1;
                        r_alu_op    <= w_opcode;
                    end
                end

                S_EXEC: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (seq_bus.alu_done) begin
                        r_state   <= S_WB;
                        r_wb_en   <= 1'b1;
                        r_wb_addr <= r_instruction[35:32];
                    end else if (w_wait_next == TIMEOUT_CNT) begin
                        r_state       <= S_HALT;
                        r_timeout_err <= 1'b1;
                        r_halted      <= 1'b1;
                        r_busy        <= 1'b0;
                        r_alu_op      <= '0;
                        r_imem_addr   <= '0;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                    end
                end

                S_WB: begin
                    r_retired   <= r_retired + 16'd1;
                    r_alu_op    <= '0;
                    r_wb_addr   <= '0;
                    r_state     <= S_FETCH;
                    r_imem_addr <= r_pc;
                    r_imem_rd   <= 1'b1;
                end

                S_HALT: begin
                    if (i_start) begin
                        r_pc          <= '0;
                        r_timeout_err <= 1'b0;
                        r_halted      <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_FETCH;
                        r_imem_addr   <= '0;
                        r_imem_rd     <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign seq_bus.imem_addr   = r_imem_addr;
    assign seq_bus.imem_rd     = r_imem_rd;
    assign seq_bus.instruction = r_instruction;
    assign seq_bus.dec_strobe  = r_dec_strobe;
    assign seq_bus.alu_start   = r_alu_start;
    assign seq_bus.alu_op      = r_alu_op;
    assign seq_bus.wb_en       = r_wb_en;
    assign seq_bus.wb_addr     = r_wb_addr;

    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_timeout_err = r_timeout_err;
    assign o_retired     = r_retired;
    assign o_pc          = r_pc;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/execute controller for the 32-bit datapath. Reads 39-bit instruction words from a synchronous instruction memory, presents each word to the decoder with a one-cycle strobe, starts the ALU for two-operand opcodes, waits for its completion and issues the register-file writeback. It is the single sequencing authority between instruction memory, decoder, ALU and register file.

## Interface
- ADDR_W, 8, instruction memory address width; PC wraps modulo 2^ADDR_W
- TIMEOUT, 255, maximum cycles spent in WAIT before abort (1..65535)
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state IDLE and all outputs to reset values
- start  in  1  level sampled per cycle; launches execution from IDLE or HALT
- imem_addr  out  ADDR_W  instruction memory read address (reset 0)
- imem_rd  out  1  read enable; memory returns data on imem_data one cycle later (reset 0)
- imem_data  in  39  instruction word: [38:36] opcode, [35:32] reg A, [31:28] reg B / [31:0] immediate
- instruction  out  39  instruction register driven to decoder (reset 0)
- dec_strobe  out  1  one-cycle pulse: instruction is valid for the decoder (reset 0)
- alu_start  out  1  one-cycle pulse launching ALU operation (reset 0)
- alu_op  out  3  opcode forwarded to ALU, held from EXEC until WB exits (reset 0)
- alu_done  in  1  ALU completion, sampled only in WAIT
- wb_en  out  1  one-cycle register-file write enable (reset 0)
- wb_addr  out  4  writeback register = instruction[35:32] (reset 0)
- busy  out  1  high in every state except IDLE and HALT (reset 0)
- halted  out  1  high in HALT (reset 0)
- timeout_err  out  1  sticky; set on WAIT timeout, cleared on restart (reset 0)
- retired  out  16  count of completed instructions, wraps at 65535 to 0 (reset 0)
- pc  out  ADDR_W  program counter (reset 0)

## Operation
- States: IDLE, FETCH, LATCH, DECODE, EXEC, WAIT, WB, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: imem_addr=pc, imem_rd=1 -> LATCH.
- LATCH: instruction <= imem_data; pc <= pc+1 (wraps to 0 after 2^ADDR_W-1) -> DECODE.
- DECODE: dec_strobe=1. Opcode 0 -> HALT (not counted as retired). Opcode 1 or 2 (immediate load into A/B) -> retired+1, FETCH. Opcodes 3-7 -> EXEC.
- EXEC: alu_start=1, alu_op=opcode, wait counter cleared -> WAIT.
- WAIT: alu_done=1 -> WB. Otherwise counter increments; when counter reaches TIMEOUT with alu_done=0 -> timeout_err=1, HALT. alu_done=1 in the same cycle the counter reaches TIMEOUT: done wins, -> WB.
- WB: wb_en=1, wb_addr=instruction[35:32], retired+1 -> FETCH.
- HALT: halted=1, outputs other than pc/retired/timeout_err/instruction at 0. start=1 -> pc=0, timeout_err=0, halted=0, -> FETCH. retired is not cleared on restart.
- start is ignored while busy.
- alu_done outside WAIT is ignored.

## Timing
- Immediate-load instruction: 3 cycles (FETCH, LATCH, DECODE).
- ALU instruction: 5+n cycles where n≥1 is WAIT cycles up to and including the one sampling alu_done.
- Halt instruction: 3 cycles from FETCH to halted=1 visible.
- dec_strobe, alu_start, wb_en are single-cycle pulses, never asserted concurrently.
- instruction changes only at the LATCH edge; stable through DECODE, EXEC, WAIT, WB.
- Reset mid-operation (any state): outputs reach reset values asynchronously; pending ALU operation is abandoned, no wb_en issued.

## Test plan
- Reset then start=1 with memory {0: 1_0011_00000005, 1: 0} (op1 A=3 imm 5, then halt) -> dec_strobe at cycle 3 with instruction=0x1_3_00000005, halted=1 after cycle 6, retired=1, pc=2.
- ALU instruction op 3, A=2, B=5, alu_done returned 2 cycles after alu_start -> alu_op=3, wb_en pulse with wb_addr=2 exactly 1 cycle after alu_done sampled, instruction total 7 cycles, retired+1.
- TIMEOUT=4, alu_done never asserted -> timeout_err=1 and halted=1 after 4 WAIT cycles, no wb_en; subsequent start clears timeout_err, pc=0.
- ADDR_W=2, four op1 instructions, no halt -> pc sequence 1,2,3,0, fetch wraps to address 0, retired continues counting.
- Assert reset while in WAIT -> all outputs 0 immediately, later alu_done produces no wb_en; start resumes from pc=0.
- alu_done asserted on the exact TIMEOUT cycle -> WB taken, timeout_err stays 0.
